ov_fifo_reader: RTL
===================

Name: ov_fifo_reader

Overview:
Downstream neighbour of the camera frame-store controller. Once the store side flags a complete frame in the AL422 FIFO (new_frame), this block resets the FIFO read pointer, generates the FIFO read clock and clocks out WIDTH×HEIGHT RGB565 pixels (two bytes each). Pixels go to the display/frame-buffer path over a valid/ready stream. The block then completes the new_frame/frame_read handshake so the store side can capture the next frame.

Parameters:
WIDTH, 320, pixels per line
HEIGHT, 240, lines per frame
RRST_CLKS, 4, number of read-clock periods with fifo_rrst_n held low

Ports:
clk_25MHz  in  1  system clock
rst  in  1  synchronous active-high reset
new_frame  in  1  level; complete frame is in the FIFO
frame_read  out  1  handshake; low while reading, high when idle/done
fifo_rclk  out  1  AL422 read clock
fifo_rrst_n  out  1  AL422 read-pointer reset, active low
fifo_oe_n  out  1  AL422 output enable, active low
fifo_data  in  8  AL422 data out
pix_data  out  16  RGB565 pixel: first byte is [15:8], second byte is [7:0]
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts the pixel
pix_x  out  9  column of pix_data
pix_y  out  8  line of pix_data
pix_sof  out  1  qualifies pixel (0,0)
pix_eol  out  1  qualifies pixel x=WIDTH-1
busy  out  1  high from leaving IDLE until entering WAIT_CLR

Behaviour:
- Reset (synchronous, highest priority):
  - fifo_rclk=0, fifo_rrst_n=1, fifo_oe_n=1, frame_read=1, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_sof=0, pix_eol=0, busy=0.
  - State goes to IDLE and phase to 0.
  - A reset mid-frame abandons the frame. The store side is not reset by this block.
- Read-clock phase ph toggles every clk_25MHz cycle while a tick is enabled:
  - ph=0: drive fifo_rclk=1.
  - ph=1: drive fifo_rclk=0.
  - Read period is 2 clocks (12.5 MHz).
- States:
  - IDLE: frame_read=1. When new_frame=1, drive frame_read<=0 and go to RRST.
  - RRST: fifo_rrst_n=0, rclk runs for RRST_CLKS full periods. Then fifo_rrst_n<=1, fifo_oe_n<=0, go to READ.
  - READ:
    - Per rclk period, fifo_data is captured on the clk_25MHz edge that ends ph=1 (falling rclk).
    - The byte toggle selects the high byte first, then the low byte.
    - On the low-byte capture, pix_data is loaded and pix_valid is set with the current x/y, sof and eol.
  - DONE: entered after the low byte of pixel (WIDTH-1, HEIGHT-1) is accepted. fifo_oe_n<=1, frame_read<=1.
  - WAIT_CLR: stay until new_frame=0, then go to IDLE. This prevents re-reading the same frame.
- Stream rules:
  - pix_valid holds, with data, x, y and flags stable, until a cycle where pix_valid&pix_ready. pix_valid drops the cycle after acceptance unless a new pixel loads in the same cycle.
  - Stall: while pix_valid=1 and pix_ready=0, no new rising fifo_rclk edge is issued. rclk parks low (ph held at 0) and the FIFO is not advanced.
  - Throughput: at most one pixel per 4 clocks.
- Counters:
  - pix_x wraps WIDTH-1 → 0 and increments pix_y.
  - pix_y reaching HEIGHT-1 with x=WIDTH-1 marks the last pixel.
  - No read beyond WIDTH×HEIGHT×2 bytes.
- new_frame dropping during RRST/READ is ignored; the frame completes.
- fifo_rclk never glitches: the only transitions are at clk edges per ph.

Decomposition:
- Shared package ov_pkg holds:
  - FRAME_W/FRAME_H defaults
  - RGB565 pixel typedef
  - reader state enum {IDLE, RRST, READ, DONE, WAIT_CLR}
- One sub-module, ov_rclk_gen:
  - inputs: phase/tick generator with enable and stall
  - outputs: fifo_rclk, capture strobe, period-done strobe
- The FSM and counters stay in ov_fifo_reader.

Test Plan:
- Reset then idle → frame_read=1, fifo_oe_n=1, fifo_rrst_n=1, pix_valid=0; new_frame=0 for 100 cycles produces no rclk edges.
- new_frame=1 with WIDTH=4/HEIGHT=2, pix_ready=1, FIFO model bytes 0x00..0x0F →
  - fifo_rrst_n low for exactly 4 rclk periods, frame_read low;
  - 8 pixels 0x0001, 0x0203 … 0x0E0F with x/y correct, sof on first, eol on x=3;
  - then frame_read=1.
- pix_ready=0 for 20 cycles on pixel 2 → pix_valid/data held, no rclk rising edge; resume yields 0x0405 next, no byte lost or duplicated.
- new_frame kept high after DONE → stays in WAIT_CLR, no second read; new_frame 0→1 starts a new frame from a reset read pointer.
- rst asserted mid-READ (pixel 3) → next cycle all outputs at reset values; a following new_frame reads from pixel (0,0) again.
- Full 320×240 frame at pix_ready=1 → exactly 76800 accepted pixels, last at x=319 y=239, at 4 clocks per pixel.

Source files
------------

// File: rtl/ov_pkg.sv
// Shared types for the camera FIFO read path: frame geometry defaults,
// the RGB565 pixel word and the reader state encoding.
package ov_pkg;

  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    IDLE,
    RRST,
    READ,
    DONE,
    WAIT_CLR
  } reader_state_t;

endpackage

// File: rtl/ov_rclk_gen.sv
// AL422 read-clock generator: 2-cycle period, rclk registered and glitch-free.
// Strobes fire combinationally in the ph=1 cycle; stall parks rclk low before a rising edge.
module ov_rclk_gen (
  input  logic clk_25MHz,
  input  logic rst,
  input  logic en,
  input  logic stall,
  output logic fifo_rclk,
  output logic cap_stb,
  output logic period_done
);

  logic ph;

  // The edge ending ph=1 is the falling rclk edge: FIFO data is settled here.
  assign cap_stb     = en & ph;
  assign period_done = en & ph;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      ph        <= 1'b0;
      fifo_rclk <= 1'b0;
    end else if (!en || ph) begin
      ph        <= 1'b0;
      fifo_rclk <= 1'b0;
    end else if (!stall) begin
      ph        <= 1'b1;
      fifo_rclk <= 1'b1;
    end
  end

endmodule

// File: rtl/ov_fifo_reader.sv
// Reads one WIDTHxHEIGHT RGB565 frame out of the AL422 per new_frame handshake.
// One pixel per 4 clocks; a held pixel (valid & !ready) stops the read clock, nothing is dropped.
module ov_fifo_reader
  import ov_pkg::*;
#(
  parameter int WIDTH     = FRAME_W,
  parameter int HEIGHT    = FRAME_H,
  parameter int RRST_CLKS = 4
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        new_frame,
  output logic        frame_read,
  output logic        fifo_rclk,
  output logic        fifo_rrst_n,
  output logic        fifo_oe_n,
  input  logic [7:0]  fifo_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy
);

  localparam int              RW        = $clog2(RRST_CLKS) + 1;
  localparam logic [RW-1:0]   RRST_LAST = RW'(RRST_CLKS - 1);
  localparam logic [8:0]      X_LAST    = 9'(WIDTH - 1);
  localparam logic [7:0]      Y_LAST    = 8'(HEIGHT - 1);

  reader_state_t   state;
  rgb565_t         pix_q;
  logic [7:0]      hi_byte;
  logic            lo_sel;
  logic            last_cap;
  logic [8:0]      nx;
  logic [7:0]      ny;
  logic [RW-1:0]   rrst_cnt;
  logic            rclk_en;
  logic            rclk_stall;
  logic            cap_stb;
  logic            period_done;

  // The clock stops once the final byte is in, so the FIFO is never over-read.
  assign rclk_en    = (state == RRST) || ((state == READ) && !last_cap);
  assign rclk_stall = pix_valid && !pix_ready;
  assign pix_data   = pix_q;

  ov_rclk_gen u_rclk_gen (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .en          (rclk_en),
    .stall       (rclk_stall),
    .fifo_rclk   (fifo_rclk),
    .cap_stb     (cap_stb),
    .period_done (period_done)
  );

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state       <= IDLE;
      frame_read  <= 1'b1;
      fifo_rrst_n <= 1'b1;
      fifo_oe_n   <= 1'b1;
      pix_q       <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      busy        <= 1'b0;
      hi_byte     <= '0;
      lo_sel      <= 1'b0;
      last_cap    <= 1'b0;
      nx          <= '0;
      ny          <= '0;
      rrst_cnt    <= '0;
    end else begin
      if (pix_valid && pix_ready)
        pix_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (new_frame) begin
            frame_read  <= 1'b0;
            fifo_rrst_n <= 1'b0;
            busy        <= 1'b1;
            rrst_cnt    <= '0;
            lo_sel      <= 1'b0;
            last_cap    <= 1'b0;
            nx          <= '0;
            ny          <= '0;
            state       <= RRST;
          end
        end

        RRST: begin
          if (period_done) begin
            if (rrst_cnt == RRST_LAST) begin
              fifo_rrst_n <= 1'b1;
              fifo_oe_n   <= 1'b0;
              state       <= READ;
            end else begin
              rrst_cnt <= rrst_cnt + RW'(1);
            end
          end
        end

        READ: begin
          if (cap_stb) begin
            lo_sel <= ~lo_sel;
            if (!lo_sel) begin
              hi_byte <= fifo_data;
            end else begin
              pix_q     <= rgb565_t'({hi_byte, fifo_data});
              pix_valid <= 1'b1;
              pix_x     <= nx;
              pix_y     <= ny;
              pix_sof   <= (nx == '0) && (ny == '0);
              pix_eol   <= (nx == X_LAST);
              last_cap  <= (nx == X_LAST) && (ny == Y_LAST);
              if (nx == X_LAST) begin
                nx <= '0;
                ny <= ny + 8'd1;
              end else begin
                nx <= nx + 9'd1;
              end
            end
          end
          if (last_cap && pix_valid && pix_ready)
            state <= DONE;
        end

        DONE: begin
          fifo_oe_n  <= 1'b1;
          frame_read <= 1'b1;
          busy       <= 1'b0;
          state      <= WAIT_CLR;
        end

        WAIT_CLR: begin
          if (!new_frame)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
